// File: rtl/branch_resolve_queue.sv
// branch_resolve_queue
//   Holds in-flight predicted branches in program order between fetch (push)
//   and execute (resolve). Each resolve is checked against the oldest entry's
//   prediction. A misprediction raises a one-cycle flush with the correct
//   fetch PC and discards every younger (wrong-path) entry. Every accepted
//   resolve also sends a one-cycle update to the 2-bit BHT predictor.
//
// Ports
//   clk, reset_n        clock (rising edge), asynchronous active-low reset
//   i_push, i_push_pc, i_push_pred, i_push_target
//                       fetch records a predicted branch
//   o_push_ready        = !full, from registered state only
//   i_resolve, i_resolve_taken, i_resolve_target
//                       execute resolves the oldest branch
//   o_flush, o_redirect_pc
//                       registered misprediction pulse and correct fetch PC
//   o_upd_branch, o_upd_pc, o_upd_taken
//                       registered predictor update pulse, index, direction
//   o_full, o_empty, o_count
//                       occupancy, from registered state
//   o_mispred_cnt       saturating misprediction counter
module branch_resolve_queue #(
  parameter int DEPTH  = 4,
  parameter int PC_W   = 32,
  parameter int IDX_W  = 6,
  parameter int PC_INC = 1
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         i_push,
  input  logic [PC_W-1:0]              i_push_pc,
  input  logic                         i_push_pred,
  input  logic [PC_W-1:0]              i_push_target,
  output logic                         o_push_ready,
  input  logic                         i_resolve,
  input  logic                         i_resolve_taken,
  input  logic [PC_W-1:0]              i_resolve_target,
  output logic                         o_flush,
  output logic [PC_W-1:0]              o_redirect_pc,
  output logic                         o_upd_branch,
  output logic [IDX_W-1:0]             o_upd_pc,
  output logic                         o_upd_taken,
  output logic                         o_full,
  output logic                         o_empty,
  output logic [$clog2(DEPTH+1)-1:0]   o_count,
  output logic [15:0]                  o_mispred_cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  // Entry storage; contents are only meaningful while counted as occupied.
  logic [PC_W-1:0] r_pc_mem     [DEPTH];
  logic            r_pred_mem   [DEPTH];
  logic [PC_W-1:0] r_target_mem [DEPTH];

  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             r_flush;
  logic [PC_W-1:0]  r_redirect_pc;
  logic             r_upd_branch;
  logic [IDX_W-1:0] r_upd_pc;
  logic             r_upd_taken;
  logic [15:0]      r_mispred_cnt;

  logic             w_full;
  logic             w_empty;
  logic             w_res_acc;
  logic             w_mispred;
  logic             w_wr_en;
  logic [PC_W-1:0]  w_head_pc;
  logic             w_head_pred;
  logic [PC_W-1:0]  w_head_target;
  logic [CNT_W-1:0] w_count_next;

  assign w_full  = (r_count == CNT_W'(DEPTH));
  assign w_empty = (r_count == '0);

  assign w_head_pc     = r_pc_mem[r_rd_ptr];
  assign w_head_pred   = r_pred_mem[r_rd_ptr];
  assign w_head_target = r_target_mem[r_rd_ptr];

  // A branch cannot resolve in its own push cycle, so an empty queue ignores
  // resolve even when a push arrives alongside it.
  assign w_res_acc = i_resolve && !w_empty;
  assign w_mispred = w_res_acc &&
                     ((i_resolve_taken != w_head_pred) ||
                      (i_resolve_taken && w_head_pred &&
                       (i_resolve_target != w_head_target)));

  // A push coinciding with a misprediction is on the wrong path: never store it.
  assign w_wr_en = i_push && !w_full && !w_mispred;

  always_comb begin
    w_count_next = r_count;
    if (w_mispred) begin
      w_count_next = '0;
    end else begin
      case ({w_wr_en, w_res_acc})
        2'b10:   w_count_next = r_count + CNT_W'(1);
        2'b01:   w_count_next = r_count - CNT_W'(1);
        default: w_count_next = r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_pc_mem[r_wr_ptr]     <= i_push_pc;
      r_pred_mem[r_wr_ptr]   <= i_push_pred;
      r_target_mem[r_wr_ptr] <= i_push_target;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_count       <= '0;
      r_flush       <= 1'b0;
      r_redirect_pc <= '0;
      r_upd_branch  <= 1'b0;
      r_upd_pc      <= '0;
      r_upd_taken   <= 1'b0;
      r_mispred_cnt <= '0;
    end else begin
      r_count      <= w_count_next;
      r_flush      <= w_mispred;
      r_upd_branch <= w_res_acc;
      if (w_wr_en) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_mispred) begin
        // Drop all younger entries by collapsing the read pointer onto the
        // write pointer.
        r_rd_ptr      <= r_wr_ptr;
        r_redirect_pc <= i_resolve_taken ? i_resolve_target
                                         : w_head_pc + PC_W'(PC_INC);
        if (r_mispred_cnt != 16'hFFFF) begin
          r_mispred_cnt <= r_mispred_cnt + 16'd1;
        end
      end else if (w_res_acc) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      if (w_res_acc) begin
        r_upd_pc    <= w_head_pc[IDX_W-1:0];
        r_upd_taken <= i_resolve_taken;
      end
    end
  end

  assign o_push_ready  = !w_full;
  assign o_full        = w_full;
  assign o_empty       = w_empty;
  assign o_count       = r_count;
  assign o_flush       = r_flush;
  assign o_redirect_pc = r_redirect_pc;
  assign o_upd_branch  = r_upd_branch;
  assign o_upd_pc      = r_upd_pc;
  assign o_upd_taken   = r_upd_taken;
  assign o_mispred_cnt = r_mispred_cnt;

endmodule
